// File: rtl/adder_decoder_pkg.sv
// Shared types and default sizes for the feedback-accumulator decoder.
// Optional wrap flag is enabled by defining ADDER_DECODER_WRAP_FLAG_EN.
package adder_decoder_pkg;

   localparam int DEFAULT_WIDTH = 16;
   localparam int DEFAULT_CNT_W = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      HOLD = 2'd2
   } state_t;

endpackage

// File: rtl/adder_feedback_decoder_if.sv
// Stream bus between accumulator, decoder and downstream consumer.
// Handshake: a beat transfers on a rising edge where valid and ready are both 1.
interface adder_feedback_decoder_if
   import adder_decoder_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
);

   logic [WIDTH-1:0] in;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] out;
   logic             out_valid;
   logic             out_ready;

   modport master (
      output in, in_valid, out_ready,
      input  in_ready, out, out_valid
   );

   modport slave (
      input  in, in_valid, out_ready,
      output in_ready, out, out_valid
   );

endinterface

// File: rtl/adder_decoder_out_reg.sv
// Single-entry valid/ready output register; data (and wrap bit when
// ADDER_DECODER_WRAP_FLAG_EN is defined) hold while the consumer stalls.
module adder_decoder_out_reg
   import adder_decoder_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic             drain,
   input  logic [WIDTH-1:0] data_in,
   output logic [WIDTH-1:0] data,
   output logic             valid
`ifdef ADDER_DECODER_WRAP_FLAG_EN
   ,
   input  logic             wrap_in,
   output logic             wrap
`endif
);

   always_ff @(posedge clk) begin
      if (reset) begin
         data  <= '0;
         valid <= 1'b0;
`ifdef ADDER_DECODER_WRAP_FLAG_EN
         wrap  <= 1'b0;
`endif
      end else if (load) begin
         data  <= data_in;
         valid <= 1'b1;
`ifdef ADDER_DECODER_WRAP_FLAG_EN
         wrap  <= wrap_in;
`endif
      end else if (drain) begin
         // Data is kept on drain; only the valid flag drops.
         valid <= 1'b0;
      end
   end

endmodule

// File: rtl/adder_feedback_decoder.sv
// Recovers increments from a running-sum stream: out = in - previous in (mod 2^WIDTH).
// Optional wrap output is enabled by defining ADDER_DECODER_WRAP_FLAG_EN.
module adder_feedback_decoder
   import adder_decoder_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH,
   parameter int CNT_W = DEFAULT_CNT_W
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     clear,
   adder_feedback_decoder_if.slave  bus,
   output logic [CNT_W-1:0]         count,
   output state_t                   state
`ifdef ADDER_DECODER_WRAP_FLAG_EN
   ,
   output logic                     wrap
`endif
);

   logic [WIDTH-1:0] prev;
   logic [WIDTH-1:0] prev_eff;
   logic [WIDTH-1:0] delta;
   logic             accept;
   logic             drain;
   logic             stall;
   state_t           state_next;

   assign bus.in_ready = !bus.out_valid | bus.out_ready;
   assign accept       = bus.in_valid & bus.in_ready;
   assign drain        = bus.out_valid & bus.out_ready;
   assign stall        = bus.out_valid & !bus.out_ready;

   // A sample arriving with clear belongs to the new stream, so decode it against 0.
   assign prev_eff = clear ? '0 : prev;
   assign delta    = bus.in - prev_eff;

   always_ff @(posedge clk) begin
      if (reset) begin
         prev <= '0;
      end else if (accept) begin
         prev <= bus.in;
      end else if (clear) begin
         prev <= '0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         count <= '0;
      end else if (drain) begin
         count <= count + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      if (clear) begin
         if (stall) begin
            state_next = HOLD;
         end else if (accept) begin
            state_next = RUN;
         end else begin
            state_next = IDLE;
         end
      end else begin
         case (state)
            IDLE:    if (accept) state_next = RUN;
            RUN:     if (stall) state_next = HOLD;
            HOLD:    if (bus.out_ready) state_next = RUN;
            default: state_next = IDLE;
         endcase
      end
   end

   adder_decoder_out_reg #(
      .WIDTH (WIDTH)
   ) u_out_reg (
      .clk     (clk),
      .reset   (reset),
      .load    (accept),
      .drain   (drain),
      .data_in (delta),
      .data    (bus.out),
      .valid   (bus.out_valid)
`ifdef ADDER_DECODER_WRAP_FLAG_EN
      ,
      .wrap_in (bus.in < prev_eff),
      .wrap    (wrap)
`endif
   );

endmodule

// File: tb/tb_adder_feedback_decoder.sv
// Directed, table-driven bench for adder_feedback_decoder with a delivery scoreboard.
// Wrap-flag checks are active when ADDER_DECODER_WRAP_FLAG_EN is defined.
module tb_adder_feedback_decoder;
   import adder_decoder_pkg::*;

   localparam int W  = 16;
   localparam int CW = 8;

   typedef struct {
      logic          rst;
      logic          clr;
      logic          iv;
      logic          ordy;
      logic [W-1:0]  din;
      logic          exp_ir;
      logic [W-1:0]  exp_out;
      logic          exp_ov;
      logic [CW-1:0] exp_cnt;
      state_t        exp_st;
      logic          exp_wr;
   } vec_t;

   logic          clk;
   logic          reset;
   logic          clear;
   logic [CW-1:0] count;
   state_t        state;
`ifdef ADDER_DECODER_WRAP_FLAG_EN
   logic          wrap;
`endif

   int checks = 0;
   int errors = 0;
   logic [W-1:0] exp_q[$];
   vec_t vecs[29];

   adder_feedback_decoder_if #(.WIDTH(W)) bus ();

   adder_feedback_decoder #(
      .WIDTH (W),
      .CNT_W (CW)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .clear (clear),
      .bus   (bus),
      .count (count),
      .state (state)
`ifdef ADDER_DECODER_WRAP_FLAG_EN
      ,
      .wrap  (wrap)
`endif
   );

   // Clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Driver: inputs at negedge, in_ready and drain scoreboard before the edge,
   // registered outputs 1 time unit after the edge.
   task automatic step(input vec_t v, input string tag);
      @(negedge clk);
      reset        = v.rst;
      clear        = v.clr;
      bus.in_valid = v.iv;
      bus.out_ready = v.ordy;
      bus.in       = v.din;
      #1;
      check({tag, " in_ready"}, {31'd0, bus.in_ready}, {31'd0, v.exp_ir});
      if (bus.out_valid && bus.out_ready && !reset) begin
         if (exp_q.size() == 0) begin
            check({tag, " unexpected_delivery"}, 32'd1, 32'd0);
         end else begin
            check({tag, " delivered"}, {16'd0, bus.out}, {16'd0, exp_q.pop_front()});
         end
      end
      @(posedge clk);
      #1;
      if (v.rst) exp_q.delete();
      else if (v.iv && v.exp_ir) exp_q.push_back(v.exp_out);
      check({tag, " out"}, {16'd0, bus.out}, {16'd0, v.exp_out});
      check({tag, " out_valid"}, {31'd0, bus.out_valid}, {31'd0, v.exp_ov});
      check({tag, " count"}, {24'd0, count}, {24'd0, v.exp_cnt});
      check({tag, " state"}, {30'd0, state}, {30'd0, v.exp_st});
`ifdef ADDER_DECODER_WRAP_FLAG_EN
      check({tag, " wrap"}, {31'd0, wrap}, {31'd0, v.exp_wr});
`endif
   endtask

   initial begin
      vec_t v;
      logic [CW-1:0] cnt_model;

      //           rst  clr  iv   ordy din     ir   out     ov   cnt    st    wr
      // basic decode
      vecs[0]  = '{1'b0,1'b0,1'b1,1'b1,16'd5,    1'b1,16'd5,    1'b1,8'd0, RUN, 1'b0};
      vecs[1]  = '{1'b0,1'b0,1'b1,1'b1,16'd10,   1'b1,16'd5,    1'b1,8'd1, RUN, 1'b0};
      vecs[2]  = '{1'b0,1'b0,1'b1,1'b1,16'd210,  1'b1,16'd200,  1'b1,8'd2, RUN, 1'b0};
      vecs[3]  = '{1'b0,1'b0,1'b0,1'b1,16'd0,    1'b1,16'd200,  1'b0,8'd3, RUN, 1'b0};
      // wrap across 2^16
      vecs[4]  = '{1'b0,1'b1,1'b0,1'b1,16'd0,    1'b1,16'd200,  1'b0,8'd3, IDLE,1'b0};
      vecs[5]  = '{1'b0,1'b0,1'b1,1'b1,16'd65530,1'b1,16'd65530,1'b1,8'd3, RUN, 1'b0};
      vecs[6]  = '{1'b0,1'b0,1'b1,1'b1,16'd4,    1'b1,16'd10,   1'b1,8'd4, RUN, 1'b1};
      vecs[7]  = '{1'b0,1'b0,1'b0,1'b1,16'd0,    1'b1,16'd10,   1'b0,8'd5, RUN, 1'b1};
      // backpressure
      vecs[8]  = '{1'b0,1'b1,1'b0,1'b1,16'd0,    1'b1,16'd10,   1'b0,8'd5, IDLE,1'b1};
      vecs[9]  = '{1'b0,1'b0,1'b1,1'b0,16'd7,    1'b1,16'd7,    1'b1,8'd5, RUN, 1'b0};
      vecs[10] = '{1'b0,1'b0,1'b1,1'b0,16'd9,    1'b0,16'd7,    1'b1,8'd5, HOLD,1'b0};
      vecs[11] = '{1'b0,1'b0,1'b1,1'b0,16'd9,    1'b0,16'd7,    1'b1,8'd5, HOLD,1'b0};
      vecs[12] = '{1'b0,1'b0,1'b1,1'b0,16'd9,    1'b0,16'd7,    1'b1,8'd5, HOLD,1'b0};
      vecs[13] = '{1'b0,1'b0,1'b1,1'b1,16'd9,    1'b1,16'd2,    1'b1,8'd6, RUN, 1'b0};
      vecs[14] = '{1'b0,1'b0,1'b0,1'b1,16'd0,    1'b1,16'd2,    1'b0,8'd7, RUN, 1'b0};
      // clear with a same-cycle accept
      vecs[15] = '{1'b0,1'b1,1'b0,1'b1,16'd0,    1'b1,16'd2,    1'b0,8'd7, IDLE,1'b0};
      vecs[16] = '{1'b0,1'b0,1'b1,1'b1,16'd100,  1'b1,16'd100,  1'b1,8'd7, RUN, 1'b0};
      vecs[17] = '{1'b0,1'b0,1'b1,1'b1,16'd150,  1'b1,16'd50,   1'b1,8'd8, RUN, 1'b0};
      vecs[18] = '{1'b0,1'b1,1'b1,1'b1,16'd30,   1'b1,16'd30,   1'b1,8'd9, RUN, 1'b0};
      vecs[19] = '{1'b0,1'b0,1'b1,1'b1,16'd45,   1'b1,16'd15,   1'b1,8'd10,RUN, 1'b0};
      vecs[20] = '{1'b0,1'b0,1'b0,1'b1,16'd0,    1'b1,16'd15,   1'b0,8'd11,RUN, 1'b0};
      // zero delta
      vecs[21] = '{1'b0,1'b1,1'b0,1'b1,16'd0,    1'b1,16'd15,   1'b0,8'd11,IDLE,1'b0};
      vecs[22] = '{1'b0,1'b0,1'b1,1'b1,16'd20,   1'b1,16'd20,   1'b1,8'd11,RUN, 1'b0};
      vecs[23] = '{1'b0,1'b0,1'b1,1'b1,16'd20,   1'b1,16'd0,    1'b1,8'd12,RUN, 1'b0};
      vecs[24] = '{1'b0,1'b0,1'b0,1'b1,16'd0,    1'b1,16'd0,    1'b0,8'd13,RUN, 1'b0};
      // clear while output stalled: pending value kept, FSM to HOLD
      vecs[25] = '{1'b0,1'b0,1'b1,1'b0,16'd50,   1'b1,16'd30,   1'b1,8'd13,RUN, 1'b0};
      vecs[26] = '{1'b0,1'b1,1'b0,1'b0,16'd0,    1'b0,16'd30,   1'b1,8'd13,HOLD,1'b0};
      vecs[27] = '{1'b0,1'b0,1'b1,1'b1,16'd60,   1'b1,16'd60,   1'b1,8'd14,RUN, 1'b0};
      vecs[28] = '{1'b0,1'b0,1'b0,1'b1,16'd0,    1'b1,16'd60,   1'b0,8'd15,RUN, 1'b0};

      reset = 1'b1;
      clear = 1'b0;
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b1;
      bus.in = '0;

      // Reset state
      @(posedge clk);
      #1;
      check("reset out", {16'd0, bus.out}, 32'd0);
      check("reset out_valid", {31'd0, bus.out_valid}, 32'd0);
      check("reset in_ready", {31'd0, bus.in_ready}, 32'd1);
      check("reset count", {24'd0, count}, 32'd0);
      check("reset state", {30'd0, state}, {30'd0, IDLE});
`ifdef ADDER_DECODER_WRAP_FLAG_EN
      check("reset wrap", {31'd0, wrap}, 32'd0);
`endif

      for (int i = 0; i < 29; i++) begin
         step(vecs[i], $sformatf("v%0d", i));
      end

      // Reset mid-stream with a stalled pending output (prev = 60)
      v = '{1'b0,1'b0,1'b1,1'b0,16'd40,1'b1,16'd65516,1'b1,8'd15,RUN, 1'b1};
      step(v, "rst_a");
      v = '{1'b1,1'b0,1'b0,1'b0,16'd0, 1'b0,16'd0,    1'b0,8'd0, IDLE,1'b0};
      step(v, "rst_b");
      v = '{1'b0,1'b0,1'b1,1'b1,16'd8, 1'b1,16'd8,    1'b1,8'd0, RUN, 1'b0};
      step(v, "rst_c");

      // Full-throughput run long enough to wrap the delta counter
      cnt_model = '0;
      for (int i = 0; i < 256; i++) begin
         cnt_model = cnt_model + 1'b1;
         v = '{1'b0,1'b0,1'b1,1'b1,16'(9 + i),1'b1,16'd1,1'b1,cnt_model,RUN,1'b0};
         step(v, $sformatf("tput%0d", i));
      end
      v = '{1'b0,1'b0,1'b0,1'b1,16'd0,1'b1,16'd1,1'b0,8'd1,RUN,1'b0};
      step(v, "tput_end");

      check("scoreboard_empty", exp_q.size(), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/adder_feedback_decoder.md
# adder_feedback_decoder

Receive-side inverse of the 16-bit feedback accumulator: takes the stream of running sums the accumulator produces and recovers the original increments, `out = in − previous in`, modulo 2^WIDTH. It sits directly downstream of the accumulator and uses a valid/ready handshake with a single-entry output register. A synchronous `clear` re-aligns the decoder whenever the upstream accumulator is reset mid-stream.

## Interface
- `WIDTH`, default 16: data width of `in`/`out`.
- `CNT_W`, default 8: width of the delta counter.

- `clk`: input, 1 bit, rising-edge clock.
- `reset`: input, 1 bit. One clock; reset is synchronous and active-high.
- `clear`: input, 1 bit. Synchronous; forces the stored previous sum to 0 (upstream accumulator was reset).
- `in`: input, WIDTH bits, running sum from the accumulator.
- `in_valid`: input, 1 bit, `in` is valid.
- `in_ready`: output, 1 bit, decoder can accept `in` this cycle.
- `out`: output, WIDTH bits, recovered increment.
- `out_valid`: output, 1 bit, `out` is valid.
- `out_ready`: input, 1 bit, downstream accepts `out`.
- `count`: output, CNT_W bits, number of deltas delivered (out_valid & out_ready), wrapping.
- `wrap`: output, 1 bit. Present only with `ADDER_DECODER_WRAP_FLAG_EN`.

## Operation
- State machine `IDLE` / `RUN` / `HOLD`:
  - `IDLE`: after reset or clear, `prev` = 0. An accept moves the FSM to `RUN`.
  - `RUN`: the output is empty or draining. If `out_valid & !out_ready`, the FSM moves to `HOLD`.
  - `HOLD`: the output is stalled and `in_ready` = 0. When `out_ready` = 1, the FSM returns to `RUN`.
- `in_ready = !out_valid | out_ready`. An accept is `in_valid & in_ready`.
- On accept:
  - `out <= in − prev`, truncated to WIDTH bits (two's-complement modular subtraction, no saturation).
  - `prev <= in`.
  - `out_valid <= 1`.
- Output drains (`out_valid & out_ready`) with no accept in the same cycle: `out_valid <= 0`, and `out` holds its value.
- Output drains and a new sample is accepted in the same cycle: `out_valid` stays 1 and `out` is updated (full throughput).
- `count` increments by 1 on every drain and wraps from 2^CNT_W−1 to 0.
- `clear`:
  - Sets `prev` to 0 and the FSM to `IDLE` (or `HOLD` if the output is still pending).
  - Does not discard a pending `out`.
  - If `clear` and an accept occur in the same cycle, the accepted sample is decoded against 0 (`out = in`), and `prev <= in`.
- Holding `in` constant across accepts yields `out` = 0. This is legal, and the value is delivered.

## Timing
- Reset values: `out` = 0, `out_valid` = 0, `in_ready` = 1 (combinational from `out_valid`), `count` = 0, `wrap` = 0, `prev` = 0, FSM = `IDLE`.
- Latency: a sample accepted at rising edge k appears on `out` with `out_valid` = 1 immediately after edge k (1 cycle).
- Throughput: 1 sample/cycle while `out_ready` = 1.
- `in_ready` depends combinationally on `out_ready`. This is the only combinational input-to-output path.
- `reset` mid-operation: the pending output is dropped and every register returns to its reset value at the next edge. `reset` has priority over `clear` and over accept.
- While `out_valid` = 1 and `out_ready` = 0, `out` and `wrap` are stable.

## Configuration
- `ADDER_DECODER_WRAP_FLAG_EN` defined:
  - The `wrap` output port exists.
  - On accept, `wrap <= (in < prev)` (unsigned compare), marking that the upstream accumulator overflowed.
  - `wrap` is registered alongside `out` and held with it.
- Undefined: there is no `wrap` port and no compare logic. All other behaviour is identical.

## Structure
- Package `adder_decoder_pkg`: state enum (`IDLE`, `RUN`, `HOLD`), default `WIDTH`/`CNT_W` localparams.
- One sub-module, `adder_decoder_out_reg`: the single-entry valid/ready output register (data + optional wrap bit, holds under stall). The subtractor, `prev`, FSM and counter stay in the top module.

## Test plan
- Basic decode: reset for 1 cycle, then `in` = 5, 10, 210 on consecutive cycles with `out_ready` = 1 → `out` = 5, 5, 200, each 1 cycle after accept; `count` = 3.
- Wrap: `in` = 65530 then 4 → `out` = 65530, 10; with the macro defined, `wrap` = 0 then 1.
- Backpressure: accept 7, hold `out_ready` = 0 for 3 cycles while `in_valid` = 1 with `in` = 9 → `in_ready` = 0, `out` = 7 stable, FSM in `HOLD`. Raise `out_ready` → 7 drains, then 9 is accepted and `out` = 2. No sample lost.
- Clear: feed 100, 150, then assert `clear` together with `in` = 30 → `out` = 100, 50, 30. Next `in` = 45 → `out` = 15.
- Reset mid-stream: after `in` = 40 is accepted with `out_ready` = 0, assert `reset` → next cycle `out_valid` = 0, `out` = 0, `count` = 0. Then `in` = 8 → `out` = 8.
- Zero delta: `in` = 20, 20 → `out` = 20, 0, both delivered, `count` = 2.
